clockdiv_prog: RTL and testbench
================================

Name: clockdiv_prog

Overview:
- Multi-channel programmable clock divider: successor to the fixed-divisor 50 MHz step-down divider.
- Each of NCH channels produces a square-wave enable clock, oclk[ch], with a runtime-programmable half-period.
- Each channel also produces a one-cycle tick, otick[ch], on each oclk rising transition, for use as a clock-enable.
- Divisor changes are glitch-free: a new value is applied only at a half-period boundary.

Parameters:
- NCH, 2: number of independent divider channels; must be 1 or more.
- WIDTH, 32: width of the half-period count and counter.
- DEFAULT_HALF, 6250000: half-period in iclk cycles loaded at reset; must fit in WIDTH.

Ports:
- iclk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- load  in  1  strobe; writes load_val into the shadow register of channel load_ch.
- load_ch  in  CHW  target channel index; CHW = max(1, $clog2(NCH)).
- load_val  in  WIDTH  new half-period in cycles; 0 means channel stopped.
- en  in  NCH  per-channel run enable.
- oclk  out  NCH  divided clock outputs, registered.
- otick  out  NCH  one-cycle pulse, high in the first cycle oclk[ch] is 1.
- pending  out  NCH  1 while the channel's shadow value is not yet applied.

Behaviour:
- Per-channel state: count (WIDTH), active half H (WIDTH), shadow (WIDTH), pending, oclk, otick.
- All state is registered on posedge iclk; there are no combinational outputs.
- Reset (synchronous; overrides everything, including a load in the same cycle):
  - count=0, H=DEFAULT_HALF, shadow=DEFAULT_HALF, pending=0, oclk=0, otick=0.
- Running (en=1, H!=0):
  - If count==H-1: count<=0, oclk<=~oclk, otick<=~oclk (high only on a 0->1 toggle). If pending: H<=shadow, pending<=0.
  - Otherwise: count<=count+1, otick<=0.
  - Period is 2H cycles; oclk is high for H cycles and low for H cycles.
  - First rising edge after reset or after enable occurs H cycles later.
- H==1: oclk toggles every cycle (period 2); otick is high every other cycle.
- Stopped (en=0 or H==0):
  - count<=0, oclk<=0, otick<=0.
  - If pending: H<=shadow, pending<=0 immediately, because there is no boundary to wait for.
- Load, for load=1 and load_ch<NCH: shadow[load_ch]<=load_val, pending<=1.
  - load_ch>=NCH: write ignored, no state change.
  - Repeated loads before the boundary: last write wins.
- Load in the same cycle as a boundary on the same channel:
  - The boundary applies the old shadow.
  - The new value stays pending (pending remains 1) and applies at the next boundary.
- Load in the same cycle as a stopped-channel apply: the new value becomes shadow with pending=1; it applies the following cycle.
- en deassert mid-period: the next cycle count=0 and oclk=0. No otick is generated. Reassert restarts a full low half-period.
- Channels are fully independent; no shared counter.
- Counter arithmetic is unsigned WIDTH-bit. Compare against H-1 only when H!=0, so there is no underflow.

Decomposition:
- Package clockdiv_pkg: function chw(nch) returning the index width, and constant HZ_50M=50000000.
- Sub-module clockdiv_chan contains one channel's counter, shadow, pending and output regs.
- Top level: decodes load_ch into a per-channel load strobe, then instantiates NCH clockdiv_chan with a generate loop.

Test Plan (NCH=2, WIDTH=8, DEFAULT_HALF=3):
- Reset then en=2'b11:
  - oclk[0] rises 3 cycles after enable, period 6, 50% duty.
  - otick[0] is high exactly 1 cycle per 6; pending=0.
- load=1, load_ch=0, load_val=5 mid low-phase:
  - pending[0]=1; the current half stays 3 cycles.
  - After the next toggle, halves are 5 cycles; pending[0] clears in the boundary cycle.
  - Channel 1 is unaffected.
- Load val 2 timed on the exact boundary cycle of ch0 (active 3, shadow pending 4):
  - The boundary applies 4; 2 stays pending and applies at the following boundary.
- load_val=0 on ch1, then en[1]=0 then 1:
  - While stopped, pending applies immediately; oclk[1] holds 0 and otick[1]=0 permanently.
  - Reload with 1: oclk toggles every cycle.
- en[0] dropped mid high-phase:
  - Next cycle oclk[0]=0, no tick.
  - Re-enable: the first rise comes 3 cycles later.
- reset asserted with load=1 in the same cycle: H returns to 3, pending=0, outputs 0. Also load_ch=3 (>=NCH): no change anywhere.

Source files
------------

// File: rtl/clockdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clockdiv_pkg;

  localparam int HZ_50M = 50000000;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clockdiv_chan.sv
// One divider channel: counter, active/shadow half-period, registered oclk/otick.
// Latency: all outputs registered; a new half-period applies at the next half boundary (at once when stopped).
module clockdiv_chan #(
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 6250000
) (
  input  logic             iclk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             oclk,
  output logic             otick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] HALF_RST = WIDTH'(DEFAULT_HALF);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             oclk_q, oclk_d;
  logic             otick_q, otick_d;

  always_comb begin
    count_d   = count_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    oclk_d    = oclk_q;
    otick_d   = 1'b0;

    if (!en || half_q == '0) begin
      count_d = '0;
      oclk_d  = 1'b0;
      if (pending_q) begin
        half_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (count_q == half_q - 1'b1) begin
      count_d = '0;
      oclk_d  = ~oclk_q;
      otick_d = ~oclk_q;
      if (pending_q) begin
        half_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      count_d = count_q + 1'b1;
    end

    // A write landing on a boundary must survive the apply above.
    if (load) begin
      shadow_d  = load_val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (reset) begin
      count_q   <= '0;
      half_q    <= HALF_RST;
      shadow_q  <= HALF_RST;
      pending_q <= 1'b0;
      oclk_q    <= 1'b0;
      otick_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      oclk_q    <= oclk_d;
      otick_q   <= otick_d;
    end
  end

  assign oclk    = oclk_q;
  assign otick   = otick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clockdiv_prog.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Latency: outputs registered per channel; no backpressure, loads to out-of-range channels are dropped.
module clockdiv_prog
  import clockdiv_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int WIDTH        = 32,
  parameter int DEFAULT_HALF = 6250000
) (
  input  logic                   iclk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [chw(NCH)-1:0]    load_ch,
  input  logic [WIDTH-1:0]       load_val,
  input  logic [NCH-1:0]         en,
  output logic [NCH-1:0]         oclk,
  output logic [NCH-1:0]         otick,
  output logic [NCH-1:0]         pending
);

  localparam int CHW = chw(NCH);

  logic [NCH-1:0] load_sel;

  always_comb begin
    load_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (load && load_ch == CHW'(i)) load_sel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clockdiv_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .iclk     (iclk),
      .reset    (reset),
      .en       (en[g]),
      .load     (load_sel[g]),
      .load_val (load_val),
      .oclk     (oclk[g]),
      .otick    (otick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clockdiv_prog.sv
// Directed bench for clockdiv_prog (WIDTH=8, DEFAULT_HALF=3); second 3-channel instance covers out-of-range load_ch.
module tb_clockdiv_prog;

  logic       iclk = 1'b0;
  logic       reset, load;
  logic [0:0] load_ch;
  logic [7:0] load_val;
  logic [1:0] en, oclk, otick, pending;

  logic       d3_load;
  logic [1:0] d3_load_ch;
  logic [7:0] d3_load_val;
  logic [2:0] d3_en, d3_oclk, d3_otick, d3_pending;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  always #5 iclk = ~iclk;

  clockdiv_prog #(.NCH(2), .WIDTH(8), .DEFAULT_HALF(3)) u_dut (
    .iclk(iclk), .reset(reset), .load(load), .load_ch(load_ch), .load_val(load_val),
    .en(en), .oclk(oclk), .otick(otick), .pending(pending)
  );

  clockdiv_prog #(.NCH(3), .WIDTH(8), .DEFAULT_HALF(3)) u_dut3 (
    .iclk(iclk), .reset(reset), .load(d3_load), .load_ch(d3_load_ch), .load_val(d3_load_val),
    .en(d3_en), .oclk(d3_oclk), .otick(d3_otick), .pending(d3_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (k=%0d): got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; load_ch = '0; load_val = '0; en = '0;
    d3_load = 1'b0; d3_load_ch = '0; d3_load_val = '0; d3_en = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_oclk", oclk, 0);
    chk("rst_otick", otick, 0);
    chk("rst_pending", pending, 0);

    // Free-running at the default half of 3: rise 3 cycles after enable, period 6.
    en = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      k = c;
      step();
      chk("a_oclk0", oclk[0], (c / 3) % 2);
      chk("a_oclk1", oclk[1], (c / 3) % 2);
      chk("a_tick0", otick[0], c % 6 == 3);
      chk("a_pend", pending, 0);
    end

    // Load 5 into ch0 mid low-phase; current half finishes at 3, then halves of 5.
    for (int c = 13; c <= 25; c++) begin
      k = c;
      load = (c == 13); load_ch = 1'b0; load_val = 8'd5;
      step();
      chk("b_oclk0", oclk[0], (c < 15) ? 0 : (((c - 15) / 5) % 2 == 0));
      chk("b_tick0", otick[0], c == 15 || c == 25);
      chk("b_pend0", pending[0], c < 15);
      chk("b_oclk1", oclk[1], (c / 3) % 2);
      chk("b_tick1", otick[1], c % 6 == 3);
      chk("b_pend1", pending[1], 0);
    end
    load = 1'b0;

    // Reset wins over a simultaneous load.
    reset = 1'b1; load = 1'b1; load_ch = 1'b0; load_val = 8'd9;
    step();
    reset = 1'b0; load = 1'b0;
    k = 0;
    chk("c_rst_oclk", oclk, 0);
    chk("c_rst_otick", otick, 0);
    chk("c_rst_pend", pending, 0);

    // Shadow 4 pending; load 2 exactly on the boundary that applies 4.
    for (int c = 1; c <= 19; c++) begin
      k = c;
      load = (c == 7 || c == 9); load_ch = 1'b0; load_val = (c == 7) ? 8'd4 : 8'd2;
      step();
      if (c <= 8)       chk("c_oclk0", oclk[0], (c / 3) % 2);
      else if (c <= 12) chk("c_oclk0", oclk[0], 1);
      else              chk("c_oclk0", oclk[0], ((c - 13) / 2) % 2);
      chk("c_tick0", otick[0], c == 3 || c == 9 || c == 15 || c == 19);
      chk("c_pend0", pending[0], c >= 7 && c <= 12);
      chk("c_oclk1", oclk[1], (c / 3) % 2);
    end
    load = 1'b0;

    // ch1: load 0, stop, restart; it stays silent, then reload 1.
    k = 100;
    load = 1'b1; load_ch = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    chk("d_pend1_set", pending[1], 1);
    en = 2'b01;
    step();
    chk("d_stop_oclk1", oclk[1], 0);
    chk("d_stop_pend1", pending[1], 0);
    en = 2'b11;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("d_zero_oclk1", oclk[1], 0);
      chk("d_zero_tick1", otick[1], 0);
    end
    load = 1'b1; load_ch = 1'b1; load_val = 8'd1;
    step();
    load = 1'b0;
    chk("d_h1_pend", pending[1], 1);
    step();
    chk("d_h1_apply", pending[1], 0);
    chk("d_h1_oclk_a", oclk[1], 0);
    step();
    chk("d_h1_oclk_b", oclk[1], 1);
    chk("d_h1_tick_b", otick[1], 1);
    step();
    chk("d_h1_oclk_c", oclk[1], 0);
    chk("d_h1_tick_c", otick[1], 0);
    step();
    chk("d_h1_oclk_d", oclk[1], 1);
    chk("d_h1_tick_d", otick[1], 1);

    // ch0 (half 2): drop en in the high phase, set half back to 3, re-enable.
    k = 200;
    n = 0;
    while (otick[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("e_wait_rise0", otick[0], 1);
    step();
    chk("e_high0", oclk[0], 1);
    en = 2'b10;
    step();
    chk("e_drop_oclk0", oclk[0], 0);
    chk("e_drop_tick0", otick[0], 0);
    load = 1'b1; load_ch = 1'b0; load_val = 8'd3;
    step();
    load = 1'b0;
    chk("e_pend0", pending[0], 1);
    step();
    chk("e_apply0", pending[0], 0);
    chk("e_idle_oclk0", oclk[0], 0);
    en = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("e_re_oclk0", oclk[0], c == 3);
      chk("e_re_tick0", otick[0], c == 3);
    end

    // Out-of-range channel index on the 3-channel instance is ignored.
    k = 300;
    d3_load = 1'b1; d3_load_ch = 2'd3; d3_load_val = 8'd7;
    step();
    d3_load = 1'b0;
    chk("f_oob_pend", d3_pending, 0);
    chk("f_oob_oclk", d3_oclk, 0);
    d3_load = 1'b1; d3_load_ch = 2'd2;
    step();
    d3_load = 1'b0;
    chk("f_ch2_pend", d3_pending, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
